// File: rtl/msk_hpc1_rnd_feed.sv
// msk_hpc1_rnd_feed: seeded 64-bit LFSR feeding refresh (latency 0) and DOM (latency 2) randomness to an HPC1 gadget
module msk_hpc1_rnd_feed #(
    parameter int d       = 2,
    parameter int REF_RND = 1,
    parameter int MUL_RND = 1,
    parameter int WARMUP  = 16,
    localparam int K      = REF_RND + MUL_RND
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [63:0]  seed_in,
    input  logic         seed_valid,
    input  logic         en,
    output logic         ready,
    output logic [K-1:0] rnd,
    output logic         rnd_ref_valid,
    output logic         rnd_mul_valid
);
    localparam int CW = (WARMUP < 2) ? 1 : $clog2(WARMUP);

    typedef enum logic [1:0] {ST_UNSEEDED, ST_WARM, ST_RUN} state_t;

    state_t             state;
    logic [63:0]        s;
    logic [63:0]        nxt;
    logic [K-1:0]       w;
    logic [CW-1:0]      cnt;
    logic [REF_RND-1:0] ref_r;
    logic               ref_v;
    logic [MUL_RND-1:0] dl0_m, dl1_m, mul_r;
    logic               dl0_v, dl1_v, mul_v;
    logic               acc;

    always_comb begin
        nxt = s;
        w = '0;
        for (int j = 0; j < K; j++) begin
            w[j] = nxt[63];
            nxt = {nxt[62:0], nxt[63] ^ nxt[62] ^ nxt[60] ^ nxt[59]};
        end
    end

    assign acc = (state == ST_RUN) && en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_UNSEEDED;
            s     <= 64'h1;
            cnt   <= '0;
            ready <= 1'b0;
            ref_r <= '0;
            ref_v <= 1'b0;
            dl0_m <= '0;
            dl0_v <= 1'b0;
            dl1_m <= '0;
            dl1_v <= 1'b0;
            mul_r <= '0;
            mul_v <= 1'b0;
        end else if (seed_valid) begin
            // reseed drops every in-flight word so no bit is ever reused
            state <= (WARMUP == 0) ? ST_RUN : ST_WARM;
            s     <= (seed_in == 64'h0) ? 64'h1 : seed_in;
            cnt   <= '0;
            ready <= (WARMUP == 0);
            ref_r <= '0;
            ref_v <= 1'b0;
            dl0_m <= '0;
            dl0_v <= 1'b0;
            dl1_m <= '0;
            dl1_v <= 1'b0;
            mul_r <= '0;
            mul_v <= 1'b0;
        end else begin
            if (state == ST_WARM || acc)
                s <= nxt;
            if (state == ST_WARM) begin
                cnt <= cnt + 1'b1;
                if (cnt == CW'(WARMUP - 1)) begin
                    state <= ST_RUN;
                    ready <= 1'b1;
                end
            end
            ref_r <= acc ? w[REF_RND-1:0] : '0;
            ref_v <= acc;
            dl0_m <= acc ? w[K-1:REF_RND] : '0;
            dl0_v <= acc;
            dl1_m <= dl0_m;
            dl1_v <= dl0_v;
            mul_r <= dl1_m;
            mul_v <= dl1_v;
        end
    end

    assign rnd           = {mul_r, ref_r};
    assign rnd_ref_valid = ref_v;
    assign rnd_mul_valid = mul_v;
endmodule

// File: tb/tb_msk_hpc1_rnd_feed.sv
// tb_msk_hpc1_rnd_feed: scoreboard bench against a reference LFSR model
module tb_msk_hpc1_rnd_feed;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] seed_in;
    logic        seed_valid;
    logic        en;
    logic        ready, rnd_ref_valid, rnd_mul_valid;
    logic [1:0]  rnd;
    logic        rdy_w, rv_w, mv_w;
    logic [1:0]  rnd_w;

    int checks = 0;
    int failures = 0;

    logic [63:0] ms;
    logic        mready;
    logic [1:0]  ref_q[$];
    logic [1:0]  mul_q[$];

    always #5 clk = ~clk;

    msk_hpc1_rnd_feed #(.d(2), .REF_RND(1), .MUL_RND(1), .WARMUP(0)) dut (
        .clk(clk), .rst(rst), .seed_in(seed_in), .seed_valid(seed_valid), .en(en),
        .ready(ready), .rnd(rnd), .rnd_ref_valid(rnd_ref_valid), .rnd_mul_valid(rnd_mul_valid)
    );

    msk_hpc1_rnd_feed #(.d(2), .REF_RND(1), .MUL_RND(1), .WARMUP(16)) dut_w (
        .clk(clk), .rst(rst), .seed_in(seed_in), .seed_valid(seed_valid), .en(en),
        .ready(rdy_w), .rnd(rnd_w), .rnd_ref_valid(rv_w), .rnd_mul_valid(mv_w)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [63:0] si, output logic [1:0] wo, output logic [63:0] so);
        so = si;
        for (int j = 0; j < 2; j++) begin
            wo[j] = so[63];
            so = {so[62:0], so[63] ^ so[62] ^ so[60] ^ so[59]};
        end
    endtask

    task automatic tick(input logic e, input logic sv, input logic [63:0] sd);
        logic [1:0]  wd, r, m;
        logic [63:0] ns;
        logic        a;
        en = e;
        seed_valid = sv;
        seed_in = sd;
        a = mready && e && !sv;
        step(ms, wd, ns);
        if (sv) begin
            ms = (sd == 64'h0) ? 64'h1 : sd;
            mready = 1'b1;
            mul_q.delete();
            repeat (3) mul_q.push_back(2'b00);
            ref_q.push_back(2'b00);
        end else begin
            if (a) ms = ns;
            ref_q.push_back(a ? {1'b1, wd[0]} : 2'b00);
            mul_q.push_back(a ? {1'b1, wd[1]} : 2'b00);
        end
        @(posedge clk);
        #1;
        r = ref_q.pop_front();
        m = mul_q.pop_front();
        chk("ref_valid", 64'(rnd_ref_valid), 64'(r[1]));
        chk("rnd_ref", 64'(rnd[0]), 64'(r[0]));
        chk("mul_valid", 64'(rnd_mul_valid), 64'(m[1]));
        chk("rnd_mul", 64'(rnd[1]), 64'(m[0]));
        chk("ready", 64'(ready), 64'(mready));
        chk("state", dut.s, ms);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] wm, tmp;
        logic [1:0]  wd;
        logic        zero_seen;
        rst = 1'b1;
        en = 1'b0;
        seed_valid = 1'b1;
        seed_in = 64'h5;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        seed_valid = 1'b0;
        ms = 64'h1;
        mready = 1'b0;
        repeat (2) mul_q.push_back(2'b00);
        chk("rst_s", dut.s, 64'h1);
        chk("rst_rnd", 64'(rnd), 64'h0);
        chk("rst_ready", 64'(ready), 64'h0);
        chk("rst_ready_w", 64'(rdy_w), 64'h0);

        repeat (10) tick(1'b0, 1'b0, 64'h0);
        repeat (4) tick(1'b1, 1'b0, 64'h0);

        tick(1'b0, 1'b1, 64'h8000_0000_0000_0000);
        tick(1'b1, 1'b0, 64'h0);
        chk("first_ref", 64'(rnd[0]), 64'h1);
        chk("first_s", dut.s, 64'h2);
        repeat (4) tick(1'b0, 1'b0, 64'h0);

        tick(1'b0, 1'b1, 64'h0);
        chk("zero_seed", dut.s, 64'h1);
        zero_seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick(1'b1, 1'b0, 64'h0);
            if (dut.s == 64'h0) zero_seen = 1'b1;
        end
        chk("never_zero", 64'(zero_seen), 64'h0);

        tick(1'b0, 1'b1, 64'hdead_beef_0123_4567);
        tick(1'b1, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 64'h0);
        tick(1'b1, 1'b0, 64'h0);
        tick(1'b1, 1'b0, 64'h0);
        repeat (5) tick(1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 200; i++) tick(1'($urandom_range(0, 1)), 1'b0, 64'h0);

        tick(1'b0, 1'b1, 64'h0f0f_1234_abcd_9876);
        chk("w_after_seed", 64'(rdy_w), 64'h0);
        for (int k = 1; k <= 16; k++) begin
            tick(1'($urandom_range(0, 1)), 1'b0, 64'h0);
            chk("w_ready", 64'(rdy_w), 64'(k == 16));
            chk("w_rnd", 64'({rv_w, mv_w, rnd_w}), 64'h0);
        end
        wm = 64'h0f0f_1234_abcd_9876;
        for (int i = 0; i < 16; i++) begin
            step(wm, wd, tmp);
            wm = tmp;
        end
        chk("w_state", dut_w.s, wm);

        tick(1'b1, 1'b0, 64'h0);
        tick(1'b0, 1'b1, 64'h1357_2468_aaaa_5555);
        chk("w_reseed_ready", 64'(rdy_w), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 64'h0);
            chk("w_drop_mul", 64'(mv_w), 64'h0);
        end
        tick(1'b1, 1'b0, 64'h0);
        tick(1'b1, 1'b1, 64'h0000_0000_0000_0042);
        chk("seed_en_s", dut.s, 64'h42);
        repeat (4) tick(1'b0, 1'b0, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/msk_hpc1_rnd_feed.md
# msk_hpc1_rnd_feed

Randomness source for the masked HPC1 AND gadget. It sits directly upstream of the gadget's `rnd` port. A seeded 64-bit LFSR is unrolled to produce `REF_RND + MUL_RND` fresh bits per enabled cycle. The refresh slice is aligned to the gadget's latency-0 randomness input and the DOM-multiplier slice to its latency-2 input, so one enable pulse supplies a complete gadget operation.

## Interface
- `d`, default 2: share count; documentation only, no logic depends on it.
- `REF_RND`, default 1: refresh bits per operation, = `ref_n_rnd` of the gadget.
- `MUL_RND`, default 1: DOM bits per operation, = d·(d−1)/2.
- `WARMUP`, default 16: discard cycles after seeding; 0 is legal.
- Derived: `K = REF_RND + MUL_RND` (LFSR steps per advance); 1 ≤ K ≤ 64.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `seed_in` in 64: seed value.
- `seed_valid` in 1: one-cycle pulse; loads `seed_in`.
- `en` in 1: request randomness for one gadget operation starting next cycle.
- `ready` out 1: generator is seeded and warmed up (state RUN).
- `rnd` out K: to gadget `rnd`. `[REF_RND-1:0]` is the refresh slice, `[K-1:REF_RND]` is the DOM slice.
- `rnd_ref_valid` out 1: refresh slice holds fresh bits this cycle.
- `rnd_mul_valid` out 1: DOM slice holds fresh bits this cycle.

## Operation
- LFSR step, state `s[63:0]`:
  - feedback `fb = s[63]^s[62]^s[60]^s[59]`
  - output bit = `s[63]`
  - next state `s' = {s[62:0], fb}`
- Advance = K chained steps in one cycle. Word bit j is the output bit of step j (bit 0 = first step).
- Refresh slice = word`[REF_RND-1:0]`; DOM slice = word`[K-1:REF_RND]`.
- FSM states: UNSEEDED (reset state), WARMUP, RUN.
  - UNSEEDED → WARMUP on `seed_valid`.
  - WARMUP → RUN when the counter reaches WARMUP. With WARMUP=0, go directly to RUN on the cycle after the seed load.
  - Any state → WARMUP on `seed_valid` (reseed). This aborts in-flight bits: the delay line and all valids are cleared.
- Seed load: `s ← seed_in`. If `seed_in == 0`, load `64'h1` (lock-up guard).
- In WARMUP the LFSR advances every cycle, `en` is ignored, and the outputs stay 0.
- In RUN the LFSR advances only in cycles with `en = 1`. `en` outside RUN is ignored.
- DOM delay line: 2-stage register of {DOM slice, valid}.
  - Shifts every cycle, independent of `en`.
  - Loads the DOM slice with valid=1 when `en` is accepted; otherwise loads 0 with valid=0.
- Invalid slices drive 0. No randomness bit is ever output twice.

## Timing
- Reset values: state UNSEEDED, `s = 64'h1`, `ready = 0`, `rnd = 0`, both valids 0, delay line cleared, warmup counter 0.
- `seed_valid` at cycle t: `s` is loaded at edge t+1. Warmup advances occur in cycles t+1 … t+WARMUP. `ready = 1` from cycle t+1+WARMUP.
- `en` accepted at cycle t (`ready = 1`):
  - `rnd[REF_RND-1:0]` and `rnd_ref_valid = 1` appear in cycle t+1.
  - The DOM slice of the same word and `rnd_mul_valid = 1` appear in cycle t+3.
  - This matches gadget latency 0 (refresh) and 2 (DOM) relative to an operation starting at t+1.
- Back-to-back `en` gives one word per cycle. Refresh and DOM slices from different operations coexist on `rnd`.
- `seed_valid` and `en` in the same cycle: the reseed wins and `en` is dropped.
- `rst` overrides everything, including `seed_valid`.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- Reset, then idle 10 cycles → `ready = 0`, `rnd = 0`, valids 0. Assert `en` → no change.
- WARMUP=0, K=2, seed `64'h8000_0000_0000_0000`, then `en` for 1 cycle → next cycle `rnd[0] = 1`, `rnd_ref_valid = 1`. Two cycles later `rnd[1] = 0`, `rnd_mul_valid = 1`. Internal `s = 64'h2`.
- Seed `0`, WARMUP=0 → behaves exactly as seed `64'h1`; the state never becomes all-zero over 1000 enables.
- WARMUP=16: `seed_valid` at t → `ready` rises exactly at t+17. `en` during warmup has no effect on `s` or the outputs.
- `en` pattern 1,0,1,1 → `rnd_ref_valid` follows it delayed 1 cycle and `rnd_mul_valid` delayed 3 cycles; invalid slices read 0. Compare against a reference LFSR model.
- Reseed in the cycle after an `en` → pending DOM bits are dropped (`rnd_mul_valid` stays 0), `ready` falls, and the state restarts from the new seed.
